memory_port_arbiter: RTL
========================

// Module: memory_port_arbiter
// PURPOSE
//  Shares the single memory port between the core pipeline (fetch/load/store) and an aux requester (program loader/debug).
//  Core has absolute priority: it cannot stall. Aux uses a req/gnt handshake.
//  Tracks in-order outstanding reads in an owner FIFO and routes each read response to its issuer.
//  Sits between the pipeline's memory outputs and the memory model/RAM.
// PARAMETERS
//  DATA_W           `DATA_WIDTH (32)  address/data width
//  MAX_OUTSTANDING  4                 owner FIFO depth, i.e. max reads in flight (>=2)
// PORTS
//  clk              in   1       clock
//  reset            in   1       synchronous, active-high
//  core_address     in   DATA_W  core address
//  core_dataWrite   in   DATA_W  core store data
//  core_length      in   2       core access length (3 = word)
//  core_store       in   1       one-cycle store strobe
//  core_load        in   1       level; held until core_readValid
//  core_loadUnsigned in  1       zero-extend load
//  core_dataRead    out  DATA_W  read data to core
//  core_readValid   out  1       core read response
//  aux_req          in   1       aux request
//  aux_we           in   1       1 = store, 0 = load
//  aux_address      in   DATA_W  aux address
//  aux_dataWrite    in   DATA_W  aux store data
//  aux_length       in   2       aux access length
//  aux_gnt          out  1       aux request accepted this cycle
//  aux_dataRead     out  DATA_W  read data to aux
//  aux_readValid    out  1       aux read response
//  mem_address, mem_dataWrite  out  DATA_W  memory-side request
//  mem_length       out  2       memory-side length
//  mem_store, mem_load, mem_loadUnsigned  out  1  one-cycle issue strobes
//  mem_dataRead     in   DATA_W  memory read data
//  mem_readValid    in   1       in-order read response
//  arb_error        out  1       sticky: response with empty FIFO, or FIFO overflow
// BEHAVIOUR
//  Reset: FIFO empty, core_readPending=0, arb_error=0.
//   All strobes, valids and gnt are 0 while reset is high. Data outputs are don't-care.
//  Core issue: core_issue = core_store | (core_load & ~core_readPending).
//   Request is muxed combinationally to mem_* in the same cycle (0-cycle latency).
//  Core load issue: sets core_readPending and pushes OWNER_CORE.
//   A held core_load therefore issues exactly one read.
//   core_readPending clears at the edge where the core response is delivered.
//  Aux grant: aux_gnt = aux_req & ~core_issue & ~(aux_we==0 & count >= MAX_OUTSTANDING-1).
//   The last FIFO slot is always reserved for the core.
//   Aux stores ignore FIFO occupancy.
//  Aux load grant: pushes OWNER_AUX. Aux always drives mem_loadUnsigned=0.
//   Aux must hold its request until aux_gnt.
//  Idle: no issue -> mem_store = mem_load = 0.
//  Response routing: mem_readValid pops the FIFO head.
//   core_readValid = mem_readValid & head==CORE; aux_readValid = mem_readValid & head==AUX.
//   mem_dataRead is forwarded to both data outputs unmodified.
//  Simultaneous push and pop in one cycle: count is unchanged. Legal when the FIFO is full.
//  Same-cycle pop of a core response and a new core_load: no re-issue that cycle.
//   pending is still 1; the core drops load the next cycle.
//  Boundaries, each sets arb_error:
//   mem_readValid with FIFO empty -> response dropped.
//   Push while full without a pop -> push dropped.
//  Reset mid-operation: FIFO and pending are flushed. Memory shares the reset, so in-flight reads are abandoned.
//  Pointers wrap modulo MAX_OUTSTANDING. count is $clog2(MAX_OUTSTANDING)+1 bits.
// CONFIGURATION
//  MEM_ARB_PERF_COUNTERS_EN defined: adds 32-bit saturating counters. All reset to 0.
//   perf_coreIssues, perf_auxIssues, perf_auxBlocked (aux_req & ~aux_gnt) as output ports.
//  Not defined: those ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
//  globalVariables.v carries DATA_WIDTH, OWNER_CORE=1'b0, OWNER_AUX=1'b1 and MEM_LEN_WORD=2'd3.
//  Sub-module arb_owner_fifo: 1-bit-wide FIFO, depth MAX_OUTSTANDING.
//   Ports push, pop, din, head, count, full, empty, overflow, underflow.
//  Top level holds the issue mux, pending flag, grant logic and error flag.
// TESTING
//  1. Core load 0x100, memory returns 0xDEADBEEF after 2 cycles.
//     -> exactly one mem_load pulse; core_readValid=1 with 0xDEADBEEF; aux_readValid=0.
//  2. Core store and aux_req in the same cycle.
//     -> mem_store from the core; aux_gnt=0; aux granted the next idle cycle.
//  3. Aux loads A, B, C back-to-back (MAX=4), then a core load.
//     -> aux gnt 3 times; a 4th aux load is blocked (count=3).
//     -> core load still issues; responses route AUX, AUX, AUX, CORE in order.
//  4. FIFO count=3: mem_readValid (pop) and a core load (push) in the same cycle.
//     -> count stays 3; no arb_error.
//  5. mem_readValid with FIFO empty -> no valid out; arb_error=1, held until reset.
//  6. Reset asserted with 2 reads in flight -> FIFO empty, pending=0.
//     -> a fresh core load issues on the first cycle after reset.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: data width, read-owner tags,
// access length encoding and a saturating counter helper.
package memory_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // Tag stored per outstanding read; identifies who receives the response.
  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_AUX  = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_LEN_WORD = 2'd3;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_owner_fifo.sv
// In-order owner FIFO: one tag bit per read in flight, popped by each memory
// read response. Dropped pushes/pops are flagged via overflow/underflow.
module arb_owner_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       din,
  output logic                       head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots_q;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = slots_q[rd_q];
  assign count = cnt_q;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when accompanied by a valid pop.
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign overflow  = push & ~do_push;
  assign underflow = pop & empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = ptr_next(rd_q);
    if (do_push) wr_d = ptr_next(wr_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots_q[wr_q] <= din;
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between the core pipeline (absolute priority) and an
// aux requester. Optional perf counters: define MEM_ARB_PERF_COUNTERS_EN.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W          = DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] core_address,
  input  logic [DATA_W-1:0] core_dataWrite,
  input  logic [1:0]        core_length,
  input  logic              core_store,
  input  logic              core_load,
  input  logic              core_loadUnsigned,
  output logic [DATA_W-1:0] core_dataRead,
  output logic              core_readValid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [DATA_W-1:0] aux_address,
  input  logic [DATA_W-1:0] aux_dataWrite,
  input  logic [1:0]        aux_length,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_dataRead,
  output logic              aux_readValid,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataWrite,
  output logic [1:0]        mem_length,
  output logic              mem_store,
  output logic              mem_load,
  output logic              mem_loadUnsigned,
  input  logic [DATA_W-1:0] mem_dataRead,
  input  logic              mem_readValid,
  output logic              arb_error
`ifdef MEM_ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_coreIssues,
  output logic [31:0]       perf_auxIssues,
  output logic [31:0]       perf_auxBlocked
`endif
);

  localparam int unsigned     CW             = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0]   AUX_LOAD_LIMIT = CW'(MAX_OUTSTANDING - 1);

  logic          pending_q, pending_d;
  logic          error_q, error_d;
  logic          core_store_issue;
  logic          core_load_issue;
  logic          core_issue;
  logic          aux_load_blocked;
  logic          aux_load_issue;
  logic          resp_valid;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_din;
  logic          fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full_unused;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic          fifo_underflow;

  assign core_store_issue = core_store & ~reset;
  assign core_load_issue  = core_load & ~pending_q & ~reset;
  assign core_issue       = core_store_issue | core_load_issue;

  // The last FIFO slot stays free for the core, which cannot be stalled.
  assign aux_load_blocked = ~aux_we & (fifo_count >= AUX_LOAD_LIMIT);
  assign aux_gnt          = aux_req & ~reset & ~core_issue & ~aux_load_blocked;
  assign aux_load_issue   = aux_gnt & ~aux_we;

  always_comb begin
    mem_address      = core_address;
    mem_dataWrite    = core_dataWrite;
    mem_length       = core_length;
    mem_store        = core_store_issue;
    mem_load         = core_load_issue;
    mem_loadUnsigned = core_load_issue & core_loadUnsigned;
    if (aux_gnt) begin
      mem_address      = aux_address;
      mem_dataWrite    = aux_dataWrite;
      mem_length       = aux_length;
      mem_store        = aux_we;
      mem_load         = ~aux_we;
      mem_loadUnsigned = 1'b0;
    end
  end

  assign fifo_push = core_load_issue | aux_load_issue;
  assign fifo_din  = aux_load_issue ? OWNER_AUX : OWNER_CORE;
  assign fifo_pop  = mem_readValid & ~reset;

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (fifo_din),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow),
    .underflow (fifo_underflow)
  );

  assign resp_valid     = fifo_pop & ~fifo_empty;
  assign core_readValid = resp_valid & (fifo_head == OWNER_CORE);
  assign aux_readValid  = resp_valid & (fifo_head == OWNER_AUX);
  assign core_dataRead  = mem_dataRead;
  assign aux_dataRead   = mem_dataRead;

  always_comb begin
    pending_d = pending_q;
    if (core_readValid)  pending_d = 1'b0;
    if (core_load_issue) pending_d = 1'b1;
    error_d = error_q | fifo_overflow | fifo_underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      error_q   <= error_d;
    end
  end

  assign arb_error = error_q;

`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [31:0] perf_core_q, perf_aux_q, perf_blk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_core_q <= '0;
      perf_aux_q  <= '0;
      perf_blk_q  <= '0;
    end else begin
      if (core_issue)          perf_core_q <= sat_inc32(perf_core_q);
      if (aux_gnt)             perf_aux_q  <= sat_inc32(perf_aux_q);
      if (aux_req && !aux_gnt) perf_blk_q  <= sat_inc32(perf_blk_q);
    end
  end

  assign perf_coreIssues = perf_core_q;
  assign perf_auxIssues  = perf_aux_q;
  assign perf_auxBlocked = perf_blk_q;
`endif

endmodule
